spi_target_engine: RTL and testbench
====================================

// Module: spi_target_engine
// PURPOSE
//  SPI target (slave) engine: the responder end of the SPI link driven by our controller engine.
//  Oversamples SCLK/CS_N/MOSI on clk_i; supports all 4 modes (CPOL/CPHA), MSB-first, DATA_WIDTH words.
//  Sits between the SPI pads and the register/FIFO layer: 1-entry TX holding buffer, 1-entry RX output.
//  Back-to-back words are allowed within one CS_N frame.
// PARAMETERS
//  DATA_WIDTH  8     word width in bits (8, 16, 32)
//  TX_FILL     1'b0  bit value shifted out for every bit of a word when TX holding buffer is empty (underrun)
// PORTS
//  clk_i         in   1           system clock
//  reset_i       in   1           synchronous, active-high reset
//  enable_i      in   1           engine enable; low forces IDLE (same as reset, except the TX holding entry is kept)
//  mode_i        in   2           SPI mode {CPOL,CPHA}; latched at CS_N assertion
//  tx_data_i     in   DATA_WIDTH  word to return to controller
//  tx_valid_i    in   1           tx_data_i valid
//  tx_ready_o    out  1           TX holding buffer empty
//  rx_data_o     out  DATA_WIDTH  received word
//  rx_valid_o    out  1           rx_data_o valid; held until rx_ready_i
//  rx_ready_i    in   1           consumer accepts rx_data_o
//  spi_clk_i     in   1           SCLK pad (asynchronous)
//  spi_cs_n_i    in   1           chip select pad, active low (asynchronous)
//  spi_mosi_i    in   1           MOSI pad (asynchronous)
//  spi_miso_o    out  1           MISO data
//  spi_miso_oe_o out  1           MISO output enable (high only while selected)
//  busy_o        out  1           frame in progress (state ACTIVE)
//  overrun_o     out  1           1-cycle pulse: word completed while rx_valid_o high and rx_ready_i low
//  underrun_o    out  1           1-cycle pulse: word load found TX holding buffer empty
// BEHAVIOUR
//  Reset: all outputs 0 except tx_ready_o=1; spi_miso_o=0; sync flops load idle (CS_N=1, SCLK=CPOL of mode_i).
//  Input sync: 2-flop sync on SCLK/CS_N/MOSI, then 1 edge-detect flop; pin edge -> action 3 clk_i later.
//  Constraint: SCLK high and low phases >= 4 clk_i cycles each; CS_N setup/hold to SCLK >= 4 clk_i.
//  Edges: leading = SCLK leaves CPOL level, trailing = returns. Sample edge = leading if CPHA=0 else trailing;
//   drive edge = the other one.
//  TX holding: tx_valid_i & tx_ready_o loads entry, tx_ready_o falls next cycle; entry consumed on word load.
//  FSM IDLE: CS_N high (synced). On synced CS_N fall (enable_i=1): latch mode, load tx_shift (entry or
//   TX_FILL + underrun_o), bit_cnt=0, word_done=0, -> ACTIVE. spi_miso_oe_o=1 same cycle.
//  FSM ACTIVE: spi_miso_o = tx_shift[MSB] (registered).
//   Sample edge: rx_shift <= {rx_shift, mosi}; bit_cnt++. On bit_cnt==DATA_WIDTH-1: bit_cnt=0, word_done=1,
//    and if !rx_valid_o | rx_ready_i: rx_data_o <= completed word, rx_valid_o=1 next cycle;
//    else overrun_o pulse, new word dropped, rx_data_o keeps old value.
//   Drive edge: if word_done: load tx_shift from entry (or TX_FILL + underrun_o), word_done=0;
//    elif bit_cnt!=0: tx_shift <<= 1; else no change (CPHA=1 first leading edge).
//   Synced CS_N rise: -> IDLE same cycle; partial rx bits discarded, bit_cnt=0, spi_miso_oe_o=0, spi_miso_o=0.
//    rx_valid_o/rx_data_o and an unconsumed TX entry are preserved.
//  rx_valid_o clears on rx_ready_i; simultaneous rx_ready_i and word completion loads the new word (no overrun).
//  Simultaneous tx_valid_i and word load with empty buffer: underrun; new entry captured for the next word.
//  mode_i changes while ACTIVE are ignored until next frame. enable_i low mid-frame: abort to IDLE as CS_N rise.
//  Reset mid-frame: immediate return to reset values; frame resumes only after a fresh CS_N fall.
// TESTING
//  Mode 0, DW=8, tx 0xA5, controller sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C, rx_valid_o=1.
//  Modes 1/2/3 each: tx 0x81, rx 0x7E -> identical data; MISO changes only on drive edge, stable at sample.
//  Two words in one frame, tx 0x11 then 0x22 loaded in time, rx 0xF0,0x0F -> both echoed, no flags.
//  Second word with TX buffer empty, TX_FILL=0 -> MISO=0x00, underrun_o one pulse; hold rx_ready_i low -> overrun_o.
//  CS_N rises after 5 bits -> busy_o=0, no rx_valid_o, next frame receives 0x5A correctly from bit 0.
//  reset_i asserted mid-word -> all outputs at reset values next cycle; tx_ready_o=1.

Source files
------------

// File: rtl/spi_target_engine.sv
// spi_target_engine: SPI target with oversampled pads, all four modes, 1-entry TX holding buffer and RX output register
module spi_target_engine #(
    parameter int   DATA_WIDTH = 8,
    parameter logic TX_FILL    = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic                  underrun_o
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t                state;
    logic [1:0]            sclk_s, cs_s, mosi_s, mode_q;
    logic                  sclk_d, cs_d, tx_full, word_done;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift, tx_hold;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic                  sclk_edge, leading, trailing, sample_e, drive_e, cs_fall, cs_rise;
    logic                  last_bit, word_load, word_complete, rx_accept;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_s <= {2{mode_i[1]}};
            sclk_d <= mode_i[1];
            cs_s   <= 2'b11;
            cs_d   <= 1'b1;
            mosi_s <= 2'b00;
        end else begin
            sclk_s <= {sclk_s[0], spi_clk_i};
            sclk_d <= sclk_s[1];
            cs_s   <= {cs_s[0], spi_cs_n_i};
            cs_d   <= cs_s[1];
            mosi_s <= {mosi_s[0], spi_mosi_i};
        end
    end
    assign sclk_edge     = sclk_s[1] ^ sclk_d;
    assign leading       = sclk_edge & (sclk_d == mode_q[1]);
    assign trailing      = sclk_edge & (sclk_s[1] == mode_q[1]);
    assign sample_e      = mode_q[0] ? trailing : leading;
    assign drive_e       = mode_q[0] ? leading : trailing;
    assign cs_fall       = cs_d & ~cs_s[1];
    assign cs_rise       = ~cs_d & cs_s[1];
    assign last_bit      = bit_cnt == CW'(DATA_WIDTH - 1);
    assign word_load     = enable_i & (state == IDLE ? cs_fall : ~cs_rise & drive_e & word_done);
    assign word_complete = busy_o & ~cs_rise & sample_e & last_bit;
    assign rx_accept     = ~rx_valid_o | rx_ready_i;
    assign tx_ready_o    = ~tx_full;
    assign busy_o        = state == ACTIVE;
    assign spi_miso_oe_o = busy_o;
    assign spi_miso_o    = tx_shift[DATA_WIDTH-1];
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_full <= 1'b0;
            tx_hold <= '0;
        end else if (word_load & tx_full) begin
            tx_full <= 1'b0;
        end else if (tx_valid_i & ~tx_full) begin
            tx_full <= 1'b1;
            tx_hold <= tx_data_i;
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i | ~enable_i) begin
            state      <= IDLE;
            mode_q     <= 2'b00;
            bit_cnt    <= '0;
            word_done  <= 1'b0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            rx_valid_o <= word_complete | (rx_valid_o & ~rx_ready_i);
            overrun_o  <= word_complete & ~rx_accept;
            underrun_o <= word_load & ~tx_full;
            if (word_complete & rx_accept) rx_data_o <= {rx_shift, mosi_s[1]};
            if (state == IDLE) begin
                if (cs_fall) begin
                    state   <= ACTIVE;
                    mode_q  <= mode_i;
                    bit_cnt <= '0;
                end
            end else if (cs_rise) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                word_done <= 1'b0;
                tx_shift  <= '0;
            end else begin
                if (sample_e) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s[1]};
                    bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
                    if (last_bit) word_done <= 1'b1;
                end
                if (drive_e & ~word_done & (bit_cnt != '0)) tx_shift <= tx_shift << 1;
            end
            if (word_load) begin
                tx_shift  <= tx_full ? tx_hold : {DATA_WIDTH{TX_FILL}};
                word_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_target_engine.sv
// tb_spi_target_engine: randomized SPI controller stimulus checked against a word-level reference model
module tb_spi_target_engine;
    localparam int   DW   = 8;
    localparam logic FILL = 1'b0;
    localparam int   H    = 8;
    logic          clk = 1'b0;
    logic          reset_i, enable_i, tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
    logic [1:0]    mode_i;
    logic [DW-1:0] tx_data_i, rx_data_o;
    logic          spi_clk_i, spi_cs_n_i, spi_mosi_i, spi_miso_o, spi_miso_oe_o;
    logic          busy_o, overrun_o, underrun_o;
    logic [DW-1:0] feed_q[$], mdl_q[$], mosi_q[$], got_q[$], exp_miso[$], act_miso[$], exp_rx[$];
    int            feed_rd, got_rd, und_cnt, ovr_cnt, exp_und, exp_ovr, act_und, act_ovr;
    int            stab_err, busy_err, checks, errors;
    bit            m_rxv;

    spi_target_engine #(.DATA_WIDTH(DW), .TX_FILL(FILL)) dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .mode_i(mode_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .spi_clk_i(spi_clk_i), .spi_cs_n_i(spi_cs_n_i), .spi_mosi_i(spi_mosi_i),
        .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
        if (overrun_o) ovr_cnt++;
        if (underrun_o) und_cnt++;
    end

    // producer side: hands queued words to the TX buffer whenever it is empty
    initial begin
        tx_valid_i = 1'b0;
        tx_data_i  = '0;
        forever begin
            @(negedge clk);
            if (tx_valid_i) tx_valid_i = 1'b0;
            else if (feed_rd < feed_q.size() && tx_ready_o && !reset_i) begin
                tx_data_i  = feed_q[feed_rd];
                tx_valid_i = 1'b1;
                feed_rd++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [DW-1:0] w);
        feed_q.push_back(w);
        mdl_q.push_back(w);
    endtask

    // drives nb bits as the controller, then predicts MISO words, RX words and flag counts
    task automatic run_frame(input logic [1:0] mode, input int nb, input bit close);
        logic [DW-1:0] w;
        logic          bits[$];
        int            u0 = und_cnt;
        int            o0 = ovr_cnt;
        int            c = nb / DW;
        int            nd = mode[0] ? (nb > 0 ? (nb - 1) / DW : 0) : c;
        exp_miso.delete(); exp_rx.delete(); act_miso.delete();
        exp_und = 0; exp_ovr = 0; stab_err = 0; busy_err = 0;
        mode_i = mode; spi_clk_i = mode[1]; spi_mosi_i = 1'b0;
        wait_cyc(H);
        spi_cs_n_i = 1'b0;
        for (int b = 0; b < nb; b++) begin
            w = mosi_q[b / DW];
            if (!mode[0]) begin
                spi_mosi_i = w[DW-1-(b%DW)];
                wait_cyc(H);
            end else begin
                wait_cyc(H);
                spi_clk_i  = ~mode[1];
                spi_mosi_i = w[DW-1-(b%DW)];
                wait_cyc(H);
            end
            bits.push_back(spi_miso_o);
            if (!busy_o || !spi_miso_oe_o) busy_err++;
            spi_clk_i = mode[0] ? mode[1] : ~mode[1];
            wait_cyc(4);
            if (spi_miso_o !== bits[$]) stab_err++;
            if (!mode[0]) begin
                wait_cyc(H - 4);
                spi_clk_i = mode[1];
            end
        end
        if (close) begin
            wait_cyc(H);
            spi_cs_n_i = 1'b1;
            wait_cyc(H);
        end
        for (int l = 0; l <= nd; l++) begin
            if (mdl_q.size() > 0) w = mdl_q.pop_front();
            else begin
                w = {DW{FILL}};
                exp_und++;
            end
            if (l < c) exp_miso.push_back(w);
        end
        for (int k = 0; k < c; k++) begin
            if (!rx_ready_i && m_rxv) exp_ovr++;
            else begin
                exp_rx.push_back(mosi_q[k]);
                if (!rx_ready_i) m_rxv = 1'b1;
            end
        end
        for (int k = 0; k < c; k++) begin
            for (int j = 0; j < DW; j++) w = {w[DW-2:0], bits[k*DW+j]};
            act_miso.push_back(w);
        end
        act_und = und_cnt - u0;
        act_ovr = ovr_cnt - o0;
    endtask

    task automatic test_reset;
        wait_cyc(4);
        checks++;
        if ({tx_ready_o, rx_valid_o, busy_o, spi_miso_oe_o, spi_miso_o, overrun_o, underrun_o, rx_data_o} !== {1'b1, 6'b0, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_in: got tx_ready=%b rx_valid=%b busy=%b oe=%b miso=%b ovr=%b und=%b rx_data=%h expected 1,0,0,0,0,0,0,00",
                     tx_ready_o, rx_valid_o, busy_o, spi_miso_oe_o, spi_miso_o, overrun_o, underrun_o, rx_data_o);
        end
        reset_i = 1'b0;
        wait_cyc(4);
        checks++;
        if ({tx_ready_o, rx_valid_o, busy_o, spi_miso_oe_o} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_out: got %b expected 1000", {tx_ready_o, rx_valid_o, busy_o, spi_miso_oe_o});
        end
    endtask

    task automatic test_mode0;
        int n;
        mosi_q = '{8'h3C};
        push_tx(8'hA5);
        run_frame(2'd0, DW, 1'b1);
        checks++;
        if (act_miso[0] !== 8'hA5) begin
            errors++;
            $display("FAIL mode0_miso: got %h expected a5", act_miso[0]);
        end
        n = got_q.size() - got_rd;
        checks++;
        if (n != 1 || got_q[got_rd] !== 8'h3C) begin
            errors++;
            $display("FAIL mode0_rx: got %0d words first %h expected 1 word 3c", n, n > 0 ? got_q[got_rd] : 8'h00);
        end
        got_rd = got_q.size();
        checks++;
        if (act_und != exp_und || act_ovr != exp_ovr || stab_err != 0 || busy_err != 0) begin
            errors++;
            $display("FAIL mode0_flags: got und=%0d ovr=%0d stab=%0d busy=%0d expected und=%0d ovr=%0d 0 0",
                     act_und, act_ovr, stab_err, busy_err, exp_und, exp_ovr);
        end
    endtask

    task automatic test_modes;
        int n;
        for (int m = 1; m < 4; m++) begin
            mosi_q = '{8'h7E};
            push_tx(8'h81);
            run_frame(2'(m), DW, 1'b1);
            n = got_q.size() - got_rd;
            checks++;
            if (act_miso[0] !== 8'h81 || n != 1 || got_q[got_rd] !== 8'h7E) begin
                errors++;
                $display("FAIL mode%0d_data: got miso=%h rx_words=%0d rx=%h expected 81 1 7e", m, act_miso[0], n, n > 0 ? got_q[got_rd] : 8'h00);
            end
            got_rd = got_q.size();
            checks++;
            if (act_und != exp_und || stab_err != 0 || busy_err != 0) begin
                errors++;
                $display("FAIL mode%0d_timing: got und=%0d stab=%0d busy=%0d expected und=%0d 0 0", m, act_und, stab_err, busy_err, exp_und);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        mosi_q = '{8'hF0, 8'h0F};
        push_tx(8'h11); push_tx(8'h22); push_tx(8'h00);
        run_frame(2'd0, 2 * DW, 1'b1);
        n = got_q.size() - got_rd;
        checks++;
        if (act_miso[0] !== 8'h11 || act_miso[1] !== 8'h22) begin
            errors++;
            $display("FAIL b2b_miso: got %h %h expected 11 22", act_miso[0], act_miso[1]);
        end
        checks++;
        if (n != 2 || got_q[got_rd] !== 8'hF0 || got_q[got_rd+n-1] !== 8'h0F) begin
            errors++;
            $display("FAIL b2b_rx: got %0d words expected f0 0f", n);
        end
        got_rd = got_q.size();
        checks++;
        if (act_und != 0 || act_ovr != 0) begin
            errors++;
            $display("FAIL b2b_flags: got und=%0d ovr=%0d expected 0 0", act_und, act_ovr);
        end
    endtask

    task automatic test_under_over;
        int n;
        mosi_q = '{DW'($urandom), DW'($urandom)};
        push_tx(8'h3C);
        rx_ready_i = 1'b0;
        run_frame(2'd1, 2 * DW, 1'b1);
        checks++;
        if (act_miso[0] !== exp_miso[0] || act_miso[1] !== exp_miso[1]) begin
            errors++;
            $display("FAIL uo_miso: got %h %h expected %h %h", act_miso[0], act_miso[1], exp_miso[0], exp_miso[1]);
        end
        checks++;
        if (act_und != exp_und || act_ovr != exp_ovr) begin
            errors++;
            $display("FAIL uo_flags: got und=%0d ovr=%0d expected und=%0d ovr=%0d", act_und, act_ovr, exp_und, exp_ovr);
        end
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== exp_rx[0]) begin
            errors++;
            $display("FAIL uo_hold: got valid=%b data=%h expected 1 %h", rx_valid_o, rx_data_o, exp_rx[0]);
        end
        rx_ready_i = 1'b1;
        m_rxv = 1'b0;
        wait_cyc(3);
        n = got_q.size() - got_rd;
        checks++;
        if (n != 1 || rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL uo_release: got words=%0d valid=%b expected 1 0", n, rx_valid_o);
        end
        got_rd = got_q.size();
    endtask

    task automatic test_abort;
        int n;
        mosi_q = '{DW'($urandom)};
        run_frame(2'd0, 5, 1'b1);
        n = got_q.size() - got_rd;
        checks++;
        if (busy_o !== 1'b0 || spi_miso_oe_o !== 1'b0 || rx_valid_o !== 1'b0 || n != 0 || act_und != exp_und) begin
            errors++;
            $display("FAIL abort_state: got busy=%b oe=%b valid=%b words=%0d und=%0d expected 0 0 0 0 %0d",
                     busy_o, spi_miso_oe_o, rx_valid_o, n, act_und, exp_und);
        end
        mosi_q = '{8'h5A};
        push_tx(DW'($urandom));
        run_frame(2'd0, DW, 1'b1);
        n = got_q.size() - got_rd;
        checks++;
        if (n != 1 || got_q[got_rd] !== 8'h5A || act_miso[0] !== exp_miso[0]) begin
            errors++;
            $display("FAIL abort_next: got words=%0d rx=%h miso=%h expected 1 5a %h", n, n > 0 ? got_q[got_rd] : 8'h00, act_miso[0], exp_miso[0]);
        end
        got_rd = got_q.size();
    endtask

    task automatic test_reset_mid;
        mosi_q = '{DW'($urandom), DW'($urandom)};
        push_tx(DW'($urandom)); push_tx(DW'($urandom)); push_tx(DW'($urandom));
        rx_ready_i = 1'b0;
        run_frame(2'd0, DW + 3, 1'b0);
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== exp_rx[0] || tx_ready_o !== (mdl_q.size() == 0) || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_before: got valid=%b data=%h tx_ready=%b busy=%b expected 1 %h %b 1",
                     rx_valid_o, rx_data_o, tx_ready_o, busy_o, exp_rx[0], mdl_q.size() == 0);
        end
        reset_i = 1'b1;
        wait_cyc(1);
        checks++;
        if ({tx_ready_o, rx_valid_o, busy_o, spi_miso_oe_o, spi_miso_o, overrun_o, underrun_o, rx_data_o} !== {1'b1, 6'b0, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL mid_reset: got tx_ready=%b rx_valid=%b busy=%b oe=%b miso=%b ovr=%b und=%b rx_data=%h expected 1,0,0,0,0,0,0,00",
                     tx_ready_o, rx_valid_o, busy_o, spi_miso_oe_o, spi_miso_o, overrun_o, underrun_o, rx_data_o);
        end
        mdl_q.delete();
        m_rxv = 1'b0;
        spi_cs_n_i = 1'b1;
        spi_clk_i = 1'b0;
        rx_ready_i = 1'b1;
        wait_cyc(2);
        reset_i = 1'b0;
        wait_cyc(10);
        got_rd = got_q.size();
    endtask

    task automatic test_random;
        int n, nw, ntx;
        logic [1:0] m;
        for (int f = 0; f < 8; f++) begin
            m = 2'($urandom_range(0, 3));
            nw = $urandom_range(1, 3);
            ntx = $urandom_range(0, nw + 1);
            mosi_q.delete();
            for (int k = 0; k < nw; k++) mosi_q.push_back(DW'($urandom));
            for (int k = 0; k < ntx; k++) push_tx(DW'($urandom));
            run_frame(m, nw * DW, 1'b1);
            for (int k = 0; k < nw; k++) begin
                checks++;
                if (act_miso[k] !== exp_miso[k]) begin
                    errors++;
                    $display("FAIL rand%0d_miso%0d: got %h expected %h (mode %0d)", f, k, act_miso[k], exp_miso[k], m);
                end
            end
            n = got_q.size() - got_rd;
            checks++;
            if (n != exp_rx.size()) begin
                errors++;
                $display("FAIL rand%0d_rxcount: got %0d expected %0d", f, n, exp_rx.size());
            end
            for (int k = 0; k < n && k < exp_rx.size(); k++) begin
                checks++;
                if (got_q[got_rd+k] !== exp_rx[k]) begin
                    errors++;
                    $display("FAIL rand%0d_rx%0d: got %h expected %h", f, k, got_q[got_rd+k], exp_rx[k]);
                end
            end
            got_rd = got_q.size();
            checks++;
            if (act_und != exp_und || act_ovr != exp_ovr || stab_err != 0 || busy_err != 0) begin
                errors++;
                $display("FAIL rand%0d_flags: got und=%0d ovr=%0d stab=%0d busy=%0d expected und=%0d ovr=%0d 0 0",
                         f, act_und, act_ovr, stab_err, busy_err, exp_und, exp_ovr);
            end
        end
    endtask

    initial begin
        reset_i = 1'b1; enable_i = 1'b1; mode_i = 2'd0; rx_ready_i = 1'b1;
        spi_clk_i = 1'b0; spi_cs_n_i = 1'b1; spi_mosi_i = 1'b0;
        test_reset;
        test_mode0;
        test_modes;
        test_back_to_back;
        test_under_over;
        test_abort;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
